// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset controller.
// Waits for a qualified PLL lock, holds every reset domain for a settling
// period, then releases the domains one at a time in index order with a
// fixed stagger. Lock loss or a software request re-sequences.
//
// Ports:
//   clk           free-running reference clock (not PLL-derived)
//   in_rst        asynchronous active-high reset
//   pll_locked    PLL lock, asynchronous to clk
//   sw_rst_req    synchronous software reset request (level, sampled per cycle)
//   out_rst       per-domain active-high resets, registered
//   ready         high only once every domain is released
//   lock_loss_cnt saturating count of lock-loss events since in_rst
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   in_rst,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] out_rst,
  output logic                   ready,
  output logic [7:0]             lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic                   sync1_q;
  logic                   lock_s_q;
  logic [NUM_DOMAINS-1:0] out_rst_q;
  logic                   ready_q;
  logic [7:0]             lock_loss_cnt_q;

  // Sequencer: lock synchronizer, shared filter/hold/stagger counter, outputs.
  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      idx_q           <= '0;
      sync1_q         <= 1'b0;
      lock_s_q        <= 1'b0;
      out_rst_q       <= '1;
      ready_q         <= 1'b0;
      lock_loss_cnt_q <= 8'd0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;

      if (state_q != WAIT_LOCK && !lock_s_q) begin
        // Lock loss outranks a software request on the same edge.
        state_q   <= WAIT_LOCK;
        cnt_q     <= '0;
        out_rst_q <= '1;
        ready_q   <= 1'b0;
        if (lock_loss_cnt_q != 8'hFF) begin
          lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
        end
      end else if (state_q != WAIT_LOCK && sw_rst_req) begin
        // A held request keeps restarting the hold period.
        state_q   <= HOLD;
        cnt_q     <= '0;
        out_rst_q <= '1;
        ready_q   <= 1'b0;
      end else begin
        case (state_q)
          WAIT_LOCK: begin
            out_rst_q <= '1;
            ready_q   <= 1'b0;
            if (!lock_s_q) begin
              cnt_q <= '0;
            end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
              state_q <= HOLD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          HOLD: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RELEASE: begin
            if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
              cnt_q            <= '0;
              out_rst_q[idx_q] <= 1'b0;
              if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RUN: begin
            out_rst_q <= '0;
            ready_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_rst       = out_rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer.
// A timestamp-based reference model predicts out_rst/ready/lock_loss_cnt
// after every edge; a separate monitor pops and compares.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int LF = 4;
  localparam int HC = 16;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         in_rst;
  logic         pll_locked;
  logic         sw_rst_req;
  logic [N-1:0] out_rst;
  logic         ready;
  logic [7:0]   lock_loss_cnt;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .LOCK_FILTER   (LF),
    .HOLD_CYCLES   (HC),
    .STAGGER_CYCLES(SC)
  ) dut (
    .clk          (clk),
    .in_rst       (in_rst),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .out_rst      (out_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  typedef struct packed {
    logic [N-1:0] rst;
    logic         rdy;
    logic [7:0]   llc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  event async_ev;

  // Reference model: edge counter, sampled-lock pipeline, and the edge (t0)
  // from which the current hold period is timed.
  int n;
  bit m_s1, m_s2;
  bit m_seq;
  int m_run;
  int m_t0;
  int m_loss;

  task automatic model_reset();
    n = 0; m_s1 = 0; m_s2 = 0; m_seq = 0; m_run = 0; m_t0 = 0; m_loss = 0;
  endtask

  task automatic model_edge(input bit pll, input bit sw);
    bit ls;
    n++;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll;
    if (!m_seq) begin
      if (ls) begin
        m_run++;
        if (m_run == LF) begin
          m_seq = 1;
          m_t0  = n;
        end
      end else begin
        m_run = 0;
      end
    end else if (!ls) begin
      m_seq = 0;
      m_run = 0;
      if (m_loss < 255) m_loss++;
    end else if (sw) begin
      m_t0 = n;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++)
      e.rst[i] = !(m_seq && n >= m_t0 + HC + (i + 1) * SC);
    e.rdy = m_seq && n >= m_t0 + HC + N * SC;
    e.llc = 8'(m_loss);
    return e;
  endfunction

  // Monitor: every sample point (falling edge, or an async-reset probe).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or async_ev);
      while (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if (out_rst !== e.rst) begin
          bad++;
          $display("FAIL out_rst t=%0t got=%b want=%b", $time, out_rst, e.rst);
        end
        total++;
        if (ready !== e.rdy) begin
          bad++;
          $display("FAIL ready t=%0t got=%b want=%b", $time, ready, e.rdy);
        end
        total++;
        if (lock_loss_cnt !== e.llc) begin
          bad++;
          $display("FAIL lock_loss_cnt t=%0t got=%0d want=%0d", $time, lock_loss_cnt, e.llc);
        end
      end
    end
  end

  task automatic step(input bit pll, input bit sw);
    @(negedge clk);
    in_rst     = 1'b0;
    pll_locked = pll;
    sw_rst_req = sw;
    @(posedge clk);
    #1;
    model_edge(pll, sw);
    expq.push_back(model_out());
  endtask

  task automatic steps(input int k, input bit pll, input bit sw);
    for (int i = 0; i < k; i++) step(pll, sw);
  endtask

  // Assert in_rst between edges and check the outputs before any clock edge.
  task automatic async_reset(input int k);
    @(negedge clk);
    #2;
    in_rst = 1'b1;
    model_reset();
    #1;
    expq.push_back(model_out());
    ->async_ev;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      expq.push_back(model_out());
    end
  endtask

  initial begin
    bit pll;
    in_rst     = 1'b1;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    #1;
    expq.push_back(model_out());
    ->async_ev;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      expq.push_back(model_out());
    end

    // Power-up: lock present from E1, full release timeline.
    steps(52, 1'b1, 1'b0);

    // Lock filter: a 3-cycle pulse must not qualify.
    async_reset(3);
    steps(3, 1'b1, 1'b0);
    steps(4, 1'b0, 1'b0);
    steps(52, 1'b1, 1'b0);

    // Repeated lock loss; the count must saturate at 255.
    for (int r = 0; r < 300; r++) begin
      steps(int'($urandom_range(1, 4)), 1'b0, 1'b0);
      if (r < 4) steps(50, 1'b1, 1'b0);
      else       steps(LF + 3 + int'($urandom_range(0, 20)), 1'b1, 1'b0);
    end
    steps(50, 1'b1, 1'b0);

    // Software reset one cycle after out_rst[0] falls.
    async_reset(2);
    steps(30, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    steps(34, 1'b1, 1'b0);

    // Lock loss and software request on the same edge in RUN; then the
    // request held through WAIT_LOCK.
    steps(20, 1'b1, 1'b0);
    steps(2, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    steps(4, 1'b0, 1'b1);
    steps(3, 1'b1, 1'b1);
    steps(52, 1'b1, 1'b0);

    // Async reset mid-RELEASE.
    async_reset(1);
    steps(35, 1'b1, 1'b0);
    async_reset(3);
    steps(52, 1'b1, 1'b0);

    // Random mix of lock drops, software requests and occasional resets.
    pll = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) pll = ~pll;
      if ($urandom_range(0, 799) == 0) async_reset(int'($urandom_range(0, 3)));
      step(pll, $urandom_range(0, 69) == 0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
